hazard_controller: RTL

- Sequencing/hazard controller for the 5-stage MIPS pipeline; sits beside the per-instruction control decoder.
- Keeps a shadow pipeline of destination-register and control info for EX/MEM/WB.
- Generates per-stage stall and flush, EX-stage forwarding selects, and a freeze while data memory is busy.
- Owns a memory-wait FSM with a timeout watchdog and a saturating stall counter.

---
 rtl/hazard_controller_pkg.sv | 30 +++
 rtl/hazard_shadow_stage.sv | 31 +++
 rtl/hazard_controller.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/hazard_controller_pkg.sv
// Shared types for the MIPS hazard controller: forwarding-select codes,
// memory-wait FSM states and the control half of a shadow pipeline entry.
package hazard_controller_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } mem_state_e;

  typedef struct packed {
    logic valid;
    logic reg_write;
    logic mem_to_reg;
    logic mem_write;
  } shadow_ctl_t;

  // The MEM-stage ALU result is younger than the WB result, so it wins.
  function automatic fwd_sel_e fwd_select(input logic mem_hit, input logic wb_hit);
    if (mem_hit) return FWD_MEM;
    if (wb_hit)  return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_shadow_stage.sv
// One registered shadow-pipeline entry: holds on hold, loads an all-zero
// bubble on bubble, otherwise captures the previous stage.
module hazard_shadow_stage
  import hazard_controller_pkg::*;
#(
  parameter int DATA_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic              bubble,
  input  shadow_ctl_t       d_ctl,
  input  logic [DATA_W-1:0] d_data,
  output shadow_ctl_t       q_ctl,
  output logic [DATA_W-1:0] q_data
);

  // NOTE: sequential state is assigned with <= so every stage samples its
  // predecessor's pre-edge value and the shadow pipeline shifts cleanly.
  always_ff @(posedge clk) begin
    if (reset)        q_ctl <= '0;
    else if (!hold)   q_ctl <= bubble ? '0 : d_ctl;
  end

  // NOTE: the register fields are not reset; valid qualifies them, and the
  // entry is always reloaded before anything reads it.
  always_ff @(posedge clk) begin
    if (!hold) q_data <= bubble ? '0 : d_data;
  end

endmodule

// File: rtl/hazard_controller.sv
// Stall/flush/forwarding controller for the 5-stage MIPS pipeline, with a
// memory-wait FSM, a sticky timeout watchdog and a saturating stall counter.
module hazard_controller
  import hazard_controller_pkg::*;
#(
  parameter int REG_W       = 5,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [REG_W-1:0] Rs_D,
  input  logic [REG_W-1:0] Rt_D,
  input  logic             UsesRt_D,
  input  logic [REG_W-1:0] WriteReg_D,
  input  logic             RegWrite_D,
  input  logic             MemtoReg_D,
  input  logic             MemWrite_D,
  input  logic             Jump_D,
  input  logic             Redirect_E,
  input  logic             MemReady,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             MemTimeout,
  output logic [CNT_W-1:0] StallCount
);

  localparam int              WAIT_W   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  shadow_ctl_t        d_ctl, e_ctl, m_ctl, w_ctl;
  logic [3*REG_W-1:0] e_data;
  logic [REG_W-1:0]   e_wr, e_rs, e_rt, m_wr, w_wr;
  logic               rst_q, quiet, freeze, lw_stall, redirect, jump;
  logic               m_fwd_ok, w_fwd_ok;
  logic               stall_f, stall_d, stall_e, stall_m, flush_d, flush_e;
  mem_state_e         state, state_next;
  logic [WAIT_W-1:0]  wait_cnt, wait_cnt_next;
  logic               timeout_q;
  logic [CNT_W-1:0]   stall_cnt;
  logic               unused_w_mem;

  assign d_ctl = '{valid: 1'b1, reg_write: RegWrite_D,
                   mem_to_reg: MemtoReg_D, mem_write: MemWrite_D};

  hazard_shadow_stage #(.DATA_W(3 * REG_W)) u_stage_e (
    .clk(CLK), .reset(Reset), .hold(freeze), .bubble(flush_e),
    .d_ctl(d_ctl), .d_data({WriteReg_D, Rs_D, Rt_D}),
    .q_ctl(e_ctl), .q_data(e_data)
  );

  hazard_shadow_stage #(.DATA_W(REG_W)) u_stage_m (
    .clk(CLK), .reset(Reset), .hold(freeze), .bubble(1'b0),
    .d_ctl(e_ctl), .d_data(e_wr), .q_ctl(m_ctl), .q_data(m_wr)
  );

  // WB retires during a freeze so its result is not forwarded twice.
  hazard_shadow_stage #(.DATA_W(REG_W)) u_stage_w (
    .clk(CLK), .reset(Reset), .hold(1'b0), .bubble(freeze),
    .d_ctl(m_ctl), .d_data(m_wr), .q_ctl(w_ctl), .q_data(w_wr)
  );

  assign e_wr = e_data[3*REG_W-1 -: REG_W];
  assign e_rs = e_data[2*REG_W-1 -: REG_W];
  assign e_rt = e_data[REG_W-1:0];
  assign unused_w_mem = w_ctl.mem_to_reg ^ w_ctl.mem_write;

  // Outputs stay quiet in the reset cycle and the one after it.
  assign quiet    = Reset | rst_q;
  assign freeze   = !quiet && m_ctl.valid && (m_ctl.mem_to_reg || m_ctl.mem_write) && !MemReady;
  assign lw_stall = !quiet && e_ctl.valid && e_ctl.mem_to_reg && (e_wr != '0) &&
                    ((e_wr == Rs_D) || (UsesRt_D && (e_wr == Rt_D)));
  assign redirect = !quiet && Redirect_E;
  assign jump     = !quiet && Jump_D;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the priority chain can infer a latch.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    if (freeze) begin
      {stall_f, stall_d, stall_e, stall_m} = 4'b1111;
    end else if (redirect) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (lw_stall) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end else if (jump) begin
      flush_d = 1'b1;
    end
  end

  assign m_fwd_ok = !quiet && m_ctl.valid && m_ctl.reg_write && !m_ctl.mem_to_reg && (m_wr != '0);
  assign w_fwd_ok = !quiet && w_ctl.valid && w_ctl.reg_write && (w_wr != '0);
  assign ForwardAE = fwd_select(m_fwd_ok && (m_wr == e_rs), w_fwd_ok && (w_wr == e_rs));
  assign ForwardBE = fwd_select(m_fwd_ok && (m_wr == e_rt), w_fwd_ok && (w_wr == e_rt));

  // wait_cnt equals the number of MEM_WAIT cycles including the current one.
  always_comb begin
    state_next    = state;
    wait_cnt_next = '0;
    case (state)
      ST_RUN:      if (freeze)   state_next = ST_MEM_WAIT;
      ST_MEM_WAIT: if (MemReady) state_next = ST_RUN;
    endcase
    if (state_next == ST_MEM_WAIT)
      wait_cnt_next = (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + WAIT_W'(1);
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      rst_q     <= 1'b1;
      state     <= ST_RUN;
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
      stall_cnt <= '0;
    end else begin
      rst_q     <= 1'b0;
      state     <= state_next;
      wait_cnt  <= wait_cnt_next;
      timeout_q <= timeout_q | (wait_cnt_next == WAIT_MAX);
      if (stall_f && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign StallF     = stall_f;
  assign StallD     = stall_d;
  assign StallE     = stall_e;
  assign StallM     = stall_m;
  assign FlushD     = flush_d;
  assign FlushE     = flush_e;
  assign MemTimeout = !quiet && timeout_q;
  assign StallCount = quiet ? '0 : stall_cnt;

endmodule
